// File: rtl/shift_phase_sequencer_if.sv
// Request/strobe bundle between the shift-operation requesters and the
// phase sequencer. The sequencer connects through the slave modport.
interface shift_phase_sequencer_if #(
  parameter int NREQ  = 2,
  parameter int CNT_W = 4,
  parameter int IDW   = 1
);
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op_mode;
  logic [CNT_W*NREQ-1:0] op_cnt;
  logic                  hold;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  ct;
  logic [3:0]            c;
  logic [1:0]            mode;
  logic                  done;
  logic [IDW-1:0]        done_id;

  modport master (
    output req, op_mode, op_cnt, hold,
    input  gnt, busy, ct, c, mode, done, done_id
  );

  modport slave (
    input  req, op_mode, op_cnt, hold,
    output gnt, busy, ct, c, mode, done, done_id
  );
endinterface

// File: rtl/shift_phase_sequencer.sv
// Round-robin arbiter and single-clock strobe sequencer for the multi-shift
// register datapath: one grant runs a load strobe followed by op_cnt rounds
// of the c[4]..c[1] phase strobes, each strobe optionally followed by
// PHASE_GAP quiet cycles.
module shift_phase_sequencer #(
  parameter int NREQ      = 2,
  parameter int CNT_W     = 4,
  parameter int IDW       = 1,
  parameter int PHASE_GAP = 0
) (
  input  logic                   main_clk,
  input  logic                   rst_n,
  shift_phase_sequencer_if.slave sif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LOAD,
    S_PH4,
    S_PH3,
    S_PH2,
    S_PH1,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   rr_q;
  logic [IDW-1:0]   win_q;
  logic [CNT_W-1:0] step_q;
  logic [3:0]       gap_q;
  logic [NREQ-1:0]  gnt_q;
  logic             busy_q;
  logic             ct_q;
  logic [3:0]       c_q;
  logic [1:0]       mode_q;
  logic             done_q;
  logic [IDW-1:0]   done_id_q;

  logic             win_vld;
  logic [IDW-1:0]   win_idx;
  logic [CNT_W-1:0] win_cnt;
  logic [1:0]       win_mode;

  // Round-robin pick: first requesting index at or after rr_q, wrapping,
  // together with that requester's count and mode slices.
  always_comb begin
    int unsigned idx;
    win_vld  = 1'b0;
    win_idx  = '0;
    win_cnt  = '0;
    win_mode = '0;
    idx      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_q) + k) % 32'(NREQ);
      if (!win_vld && sif.req[IDW'(idx)]) begin
        win_vld  = 1'b1;
        win_idx  = IDW'(idx);
        win_cnt  = CNT_W'(sif.op_cnt >> (idx * 32'(CNT_W)));
        win_mode = 2'(sif.op_mode >> (2 * idx));
      end
    end
  end

  // Sequencer FSM with registered strobes; hold freezes every register so
  // the pending strobe is simply re-presented once hold drops.
  always_ff @(posedge main_clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      win_q     <= '0;
      step_q    <= '0;
      gap_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      ct_q      <= 1'b0;
      c_q       <= '0;
      mode_q    <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else if (!sif.hold) begin
      unique case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            state_q <= S_GRANT;
            win_q   <= win_idx;
            step_q  <= win_cnt;
            mode_q  <= win_mode;
            gnt_q   <= NREQ'(1) << win_idx;
            busy_q  <= 1'b1;
          end
        end
        S_GRANT: begin
          state_q <= S_LOAD;
          gnt_q   <= '0;
          ct_q    <= 1'b1;
          rr_q    <= (win_q == IDW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        end
        S_LOAD: begin
          ct_q  <= 1'b0;
          gap_q <= '0;
          if (step_q == '0) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            done_id_q <= win_q;
          end else begin
            state_q <= S_PH4;
            c_q     <= 4'b1000;
          end
        end
        S_PH4, S_PH3, S_PH2, S_PH1: begin
          // Strobe cycle is gap_q==0; the following PHASE_GAP cycles are quiet.
          if (gap_q != 4'(PHASE_GAP)) begin
            gap_q <= gap_q + 4'd1;
            c_q   <= '0;
          end else begin
            gap_q <= '0;
            unique case (state_q)
              S_PH4: begin
                state_q <= S_PH3;
                c_q     <= 4'b0100;
              end
              S_PH3: begin
                state_q <= S_PH2;
                c_q     <= 4'b0010;
              end
              S_PH2: begin
                state_q <= S_PH1;
                c_q     <= 4'b0001;
              end
              S_PH1: begin
                if (step_q == CNT_W'(1)) begin
                  state_q   <= S_DONE;
                  c_q       <= '0;
                  done_q    <= 1'b1;
                  done_id_q <= win_q;
                end else begin
                  state_q <= S_PH4;
                  c_q     <= 4'b1000;
                end
                step_q <= step_q - 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_DONE: begin
          state_q   <= S_IDLE;
          done_q    <= 1'b0;
          done_id_q <= '0;
          busy_q    <= 1'b0;
          mode_q    <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes are suppressed for any cycle in which hold is high.
  assign sif.gnt     = sif.hold ? '0 : gnt_q;
  assign sif.ct      = ct_q & ~sif.hold;
  assign sif.c       = sif.hold ? '0 : c_q;
  assign sif.done    = done_q & ~sif.hold;
  assign sif.done_id = done_id_q;
  assign sif.busy    = busy_q;
  assign sif.mode    = mode_q;

endmodule

// File: tb/tb_shift_phase_sequencer.sv
// Scoreboard bench: two sequencers (PHASE_GAP 0 and 2) share one stimulus
// stream; a frame-list reference model predicts every strobe event and the
// per-cycle busy/mode status.
module tb_shift_phase_sequencer;
  localparam int NREQ  = 2;
  localparam int CNT_W = 4;
  localparam int IDW   = 1;
  localparam int GAP_A = 0;
  localparam int GAP_B = 2;
  localparam int NDUT  = 2;

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic            ct;
    logic [3:0]      c;
    logic            done;
    logic [IDW-1:0]  did;
  } frame_t;

  typedef struct {
    int     cyc;
    frame_t f;
  } ev_t;

  typedef struct {
    int         cyc;
    logic       busy;
    logic [1:0] mode;
  } st_t;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op_mode;
  logic [CNT_W*NREQ-1:0] op_cnt;
  logic                  hold;

  shift_phase_sequencer_if #(.NREQ(NREQ), .CNT_W(CNT_W), .IDW(IDW)) if_a ();
  shift_phase_sequencer_if #(.NREQ(NREQ), .CNT_W(CNT_W), .IDW(IDW)) if_b ();

  assign if_a.req     = req;
  assign if_a.op_mode = op_mode;
  assign if_a.op_cnt  = op_cnt;
  assign if_a.hold    = hold;
  assign if_b.req     = req;
  assign if_b.op_mode = op_mode;
  assign if_b.op_cnt  = op_cnt;
  assign if_b.hold    = hold;

  shift_phase_sequencer #(.NREQ(NREQ), .CNT_W(CNT_W), .IDW(IDW), .PHASE_GAP(GAP_A)) u_gap0 (
    .main_clk (clk),
    .rst_n    (rst_n),
    .sif      (if_a)
  );

  shift_phase_sequencer #(.NREQ(NREQ), .CNT_W(CNT_W), .IDW(IDW), .PHASE_GAP(GAP_B)) u_gap2 (
    .main_clk (clk),
    .rst_n    (rst_n),
    .sif      (if_b)
  );

  logic [NREQ-1:0] o_gnt  [NDUT];
  logic            o_busy [NDUT];
  logic            o_ct   [NDUT];
  logic [3:0]      o_c    [NDUT];
  logic [1:0]      o_mode [NDUT];
  logic            o_done [NDUT];
  logic [IDW-1:0]  o_did  [NDUT];

  assign o_gnt[0]  = if_a.gnt;     assign o_gnt[1]  = if_b.gnt;
  assign o_busy[0] = if_a.busy;    assign o_busy[1] = if_b.busy;
  assign o_ct[0]   = if_a.ct;      assign o_ct[1]   = if_b.ct;
  assign o_c[0]    = if_a.c;       assign o_c[1]    = if_b.c;
  assign o_mode[0] = if_a.mode;    assign o_mode[1] = if_b.mode;
  assign o_done[0] = if_a.done;    assign o_done[1] = if_b.done;
  assign o_did[0]  = if_a.done_id; assign o_did[1]  = if_b.done_id;

  // Reference model: each running operation is the list of output frames it
  // still has to present, one frame per un-held cycle.
  frame_t     scr   [NDUT][$];
  ev_t        ev_q  [NDUT][$];
  st_t        st_q  [NDUT][$];
  int         rr_m  [NDUT];
  logic [1:0] mode_m[NDUT];
  int         dones [NDUT];
  int         cyc_k;
  int         n_cmp;
  int         n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic build(input int d, input int w, input int n);
    frame_t f;
    int g;
    g = (d == 0) ? GAP_A : GAP_B;
    f = '0; f.gnt = NREQ'(1) << w; scr[d].push_back(f);
    f = '0; f.ct = 1'b1;           scr[d].push_back(f);
    for (int s = 0; s < n; s++) begin
      for (int p = 3; p >= 0; p--) begin
        f = '0; f.c = 4'(1) << p; scr[d].push_back(f);
        for (int i = 0; i < g; i++) scr[d].push_back(frame_t'(0));
      end
    end
    f = '0; f.done = 1'b1; f.did = IDW'(w); scr[d].push_back(f);
  endtask

  task automatic model_emit();
    for (int d = 0; d < NDUT; d++) begin
      st_t    s;
      ev_t    e;
      frame_t f;
      s.cyc  = cyc_k;
      s.busy = (scr[d].size() != 0);
      s.mode = mode_m[d];
      st_q[d].push_back(s);
      if (scr[d].size() != 0 && !hold) begin
        f = scr[d][0];
        if (f != '0) begin
          e.cyc = cyc_k;
          e.f   = f;
          ev_q[d].push_back(e);
          if (f.done) dones[d]++;
        end
      end
    end
  endtask

  task automatic model_advance();
    for (int d = 0; d < NDUT; d++) begin
      int               w;
      logic [NREQ-1:0]  rq;
      logic [CNT_W-1:0] cv;
      if (!rst_n) begin
        scr[d].delete();
        rr_m[d]   = 0;
        mode_m[d] = '0;
      end else if (hold) begin
      end else if (scr[d].size() != 0) begin
        void'(scr[d].pop_front());
        if (scr[d].size() == 0) mode_m[d] = '0;
      end else if (req != '0) begin
        w = -1;
        for (int i = 0; i < NREQ; i++) begin
          rq = req >> ((rr_m[d] + i) % NREQ);
          if (w < 0 && rq[0]) w = (rr_m[d] + i) % NREQ;
        end
        cv        = CNT_W'(op_cnt >> (w * CNT_W));
        mode_m[d] = 2'(op_mode >> (2 * w));
        build(d, w, int'(cv));
        rr_m[d]   = (w + 1) % NREQ;
      end
    end
  endtask

  // One clock cycle of stimulus; op_mode/op_cnt are set by the caller.
  task automatic step(input logic r, input logic [NREQ-1:0] rqv, input logic h);
    rst_n = r;
    req   = rqv;
    hold  = h;
    model_emit();
    model_advance();
    @(posedge clk);
    #1;
    cyc_k++;
  endtask

  task automatic run_idle(input int maxc);
    int g;
    g = 0;
    while ((scr[0].size() != 0 || scr[1].size() != 0) && g < maxc) begin
      step(1'b1, '0, 1'b0);
      g++;
    end
    step(1'b1, '0, 1'b0);
  endtask

  // Monitor: per-cycle busy/mode status, plus an event pop whenever a DUT
  // presents any strobe.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      st_t    s;
      ev_t    e;
      frame_t act;
      if (st_q[d].size() != 0) begin
        s = st_q[d].pop_front();
        n_cmp++;
        if (o_busy[d] !== s.busy || o_mode[d] !== s.mode) begin
          n_bad++;
          $display("FAIL status dut%0d cyc %0d: busy/mode got %b/%b required %b/%b",
                   d, s.cyc, o_busy[d], o_mode[d], s.busy, s.mode);
        end
        while (ev_q[d].size() != 0 && ev_q[d][0].cyc < s.cyc) begin
          e = ev_q[d].pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL missed dut%0d: event for cyc %0d not seen (gnt=%b ct=%b c=%b done=%b)",
                   d, e.cyc, e.f.gnt, e.f.ct, e.f.c, e.f.done);
        end
        act.gnt  = o_gnt[d];
        act.ct   = o_ct[d];
        act.c    = o_c[d];
        act.done = o_done[d];
        act.did  = o_done[d] ? o_did[d] : '0;
        if (act !== '0) begin
          n_cmp++;
          if (ev_q[d].size() == 0) begin
            n_bad++;
            $display("FAIL event dut%0d cyc %0d: got gnt=%b ct=%b c=%b done=%b id=%0d, required no strobe",
                     d, s.cyc, act.gnt, act.ct, act.c, act.done, act.did);
          end else begin
            e = ev_q[d].pop_front();
            if (e.cyc != s.cyc || e.f !== act) begin
              n_bad++;
              $display("FAIL event dut%0d cyc %0d: got gnt=%b ct=%b c=%b done=%b id=%0d, required cyc %0d gnt=%b ct=%b c=%b done=%b id=%0d",
                       d, s.cyc, act.gnt, act.ct, act.c, act.done, act.did,
                       e.cyc, e.f.gnt, e.f.ct, e.f.c, e.f.done, e.f.did);
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int d0;
    n_cmp   = 0;
    n_bad   = 0;
    cyc_k   = 0;
    rst_n   = 1'b0;
    req     = '1;
    hold    = 1'b0;
    op_mode = '0;
    op_cnt  = '0;
    for (int d = 0; d < NDUT; d++) begin
      rr_m[d]   = 0;
      mode_m[d] = '0;
      dones[d]  = 0;
    end
    @(posedge clk);
    #1;
    cyc_k = 1;

    // Reset held with both requesters asking.
    step(1'b0, 2'b11, 1'b0);
    step(1'b0, 2'b11, 1'b0);
    step(1'b1, 2'b00, 1'b0);

    // Single op, requester 0, two steps, mode 2'b10.
    op_mode = 4'b0010;
    op_cnt  = {4'd0, 4'd2};
    step(1'b1, 2'b01, 1'b0);
    run_idle(200);

    // Both requesting across three ops, one step each.
    step(1'b0, 2'b00, 1'b0);
    op_mode = 4'b1101;
    op_cnt  = {4'd1, 4'd1};
    d0 = dones[0];
    g  = 0;
    while (dones[0] < d0 + 3 && g < 200) begin
      step(1'b1, 2'b11, 1'b0);
      g++;
    end
    run_idle(200);

    // Zero-step op: load strobe then done.
    op_cnt = {4'd5, 4'd0};
    step(1'b1, 2'b01, 1'b0);
    run_idle(200);

    // One-step op (gap timing visible on the PHASE_GAP=2 instance).
    op_cnt = {4'd1, 4'd1};
    step(1'b1, 2'b10, 1'b0);
    run_idle(200);

    // Hold for three cycles starting at cycle 4 of an op.
    op_cnt = {4'd1, 4'd1};
    step(1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 1'b1);
    run_idle(200);

    // Hold while idle blocks arbitration.
    step(1'b1, 2'b11, 1'b1);
    step(1'b1, 2'b11, 1'b1);
    step(1'b1, 2'b00, 1'b0);

    // Reset at cycle 5 of an op won by requester 0; pointer must return to 0.
    op_cnt = {4'd3, 4'd3};
    step(1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    run_idle(200);

    // Randomized traffic with occasional hold and reset.
    for (int i = 0; i < 600; i++) begin
      op_mode = 4'($urandom);
      op_cnt  = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      step(($urandom_range(0, 199) != 0), 2'($urandom), ($urandom_range(0, 9) == 0));
    end
    run_idle(300);

    for (int d = 0; d < NDUT; d++) begin
      n_cmp++;
      if (ev_q[d].size() != 0) begin
        n_bad++;
        $display("FAIL leftover dut%0d: %0d expected events never seen, required 0",
                 d, ev_q[d].size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
